pwl_coeff_fetch: RTL and testbench
==================================

# pwl_coeff_fetch

Stage directly downstream of the fp16 interval classifier in the piecewise-linear (PWL) activation pipeline. Takes each fp16 sample with its one-hot interval vector, encodes the interval to an index, and looks up that segment's slope/bias pair in a programmable coefficient table. It presents the registered operand triple `{s, slope, bias}` to the fp16 multiply-add stage behind a valid/ready handshake.

## Interface
- `WIDTH`, default 16: sample and coefficient width (fp16).
- `NUM`, default 8: number of intervals and table entries.
- `IDX_W`, localparam `$clog2(NUM)`: index width.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cfg_we_i`  in  1  coefficient table write strobe.
- `cfg_addr_i`  in  IDX_W  table entry to write.
- `cfg_slope_i`  in  WIDTH  slope value to write.
- `cfg_bias_i`  in  WIDTH  bias value to write.
- `in_valid_i`  in  1  upstream sample valid.
- `in_ready_o`  out  1  this stage accepts a sample.
- `s_i`  in  WIDTH  fp16 sample.
- `interval_i`  in  NUM  one-hot interval from the classifier.
- `out_valid_o`  out  1  operand triple valid.
- `out_ready_i`  in  1  downstream accepts.
- `s_o`  out  WIDTH  sample, passed through unchanged.
- `slope_o`  out  WIDTH  selected slope.
- `bias_o`  out  WIDTH  selected bias.
- `idx_o`  out  IDX_W  selected interval index.
- `err_o`  out  1  `interval_i` was not exactly one-hot.
- `err_cnt_o`  out  16  error count; present only with `PWL_STATS_EN`.

## Operation
- Two register stages:
  - S1 captures `s_i`, the encoded index, and the error flag.
  - S2 reads the table at the S1 index and captures all outputs.
- Encoding rules:
  - Index = position of the lowest set bit of `interval_i`.
  - All-zero vector: index 0, `err_o=1`.
  - More than one bit set: lowest set bit wins, `err_o=1`.
  - Exactly one bit set: `err_o=0`.
- Table: NUM entries of `{slope, bias}`.
  - When `cfg_we_i=1`, the entry at `cfg_addr_i` is written at the clock edge.
  - Writes are independent of the handshake.
  - `cfg_addr_i >= NUM`: the write is ignored.
- Handshakes:
  - Input transfer occurs when `in_valid_i & in_ready_o`.
  - Output transfer occurs when `out_valid_o & out_ready_i`.
- Each stage loads when it is empty or its downstream transfers in the same cycle. Bubbles collapse.
  - `in_ready_o = !v1 | (!v2 | out_ready_i)`, where v1 and v2 are the stage valids.
- Stall: while `out_valid_o=1 & out_ready_i=0`, all outputs hold stable and no sample is dropped or duplicated.

## Timing
- Latency: 2 cycles from input transfer to `out_valid_o`, with no stall.
- Throughput: 1 sample per cycle.
- Reset values:
  - `out_valid_o=0`, `in_ready_o=1` once reset is released.
  - `s_o`, `slope_o`, `bias_o`, `idx_o`, `err_o` = 0.
  - All table entries = 0.
  - `err_cnt_o=0`.
- Read/write collision: a write in the same cycle that S2 captures the same entry gives S2 the old value. The new value is visible to S2 captures from the next cycle on.
- Reset asserted mid-operation: both stages are emptied immediately, in-flight samples are discarded, and the table is cleared.
- `in_ready_o` is combinational from `out_ready_i`. It has no path from `in_valid_i`.

## Configuration
- `PWL_STATS_EN` defined:
  - Adds a 16-bit counter on port `err_cnt_o`.
  - Increments once per output transfer that has `err_o=1`.
  - Saturates at 0xFFFF. Cleared only by reset.
- `PWL_STATS_EN` undefined: the counter and the `err_cnt_o` port do not exist. All other behaviour is identical.

## Structure
- Package `pwl_pkg`:
  - Constants `WIDTH`, `NUM`, `IDX_W`.
  - `coeff_t` packed struct `{slope, bias}`.
  - `stage_t` struct for S1 contents `{s, idx, err}`.
- One sub-module: `onehot_to_idx`. Combinational, NUM-bit vector in, `{idx, err}` out, lowest-bit priority.

## Test plan
- Program entry 3 = `{0x3800, 0x3C00}`. Send `s_i=0x4000`, `interval_i=8'b0000_1000`, with `out_ready_i=1`. Two cycles later expect `out_valid_o=1`, `s_o=0x4000`, `slope_o=0x3800`, `bias_o=0x3C00`, `idx_o=3`, `err_o=0`.
- Send `interval_i=8'b0000_0000` -> `idx_o=0`, `err_o=1`. Send `interval_i=8'b0010_0100` -> `idx_o=2`, `err_o=1`.
- Back-to-back stream of 8 samples with intervals 0..7 while `out_ready_i` toggles 1,0,0,1,…. Expect all 8 outputs in order, each with its table entry, values held during stalls, and `in_ready_o` low only while both stages are full and stalled.
- Write entry 5 in the same cycle S2 captures an index-5 sample -> old coefficients out. Next index-5 sample -> new coefficients.
- Assert `rst_i` while both stages are valid -> `out_valid_o=0` immediately, table reads 0, and the next sample outputs `slope_o=0`, `bias_o=0`.
- With `PWL_STATS_EN`: 3 erroneous samples transferred -> `err_cnt_o=3`. Force the counter to 0xFFFF plus one more error -> stays 0xFFFF.

Source files
------------

// File: rtl/pwl_pkg.sv
// Shared types and constants for the PWL coefficient fetch stage.
package pwl_pkg;

  localparam int WIDTH = 16;
  localparam int NUM   = 8;
  localparam int IDX_W = $clog2(NUM);

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [WIDTH-1:0] slope;
    logic [WIDTH-1:0] bias;
  } coeff_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [IDX_W-1:0] idx;
    logic             err;
  } stage_t;

endpackage

// File: rtl/pwl_coeff_fetch_onehot_to_idx.sv
// One-hot interval vector to index encoder; lowest set bit wins, err flags
// any vector that is not exactly one-hot.
module onehot_to_idx #(
  parameter  int NUM   = pwl_pkg::NUM,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
);
  import pwl_pkg::*;

  localparam logic [NUM-1:0] ONE = {{(NUM-1){1'b0}}, 1'b1};

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one assigned.
    for (int i = NUM - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
    err_o = (vec_i == '0) | ((vec_i & (vec_i - ONE)) != '0);
  end

endmodule

// File: rtl/pwl_coeff_fetch.sv
// PWL coefficient fetch: encodes the interval, looks up {slope, bias} and
// presents {s, slope, bias} behind valid/ready. Optional: PWL_STATS_EN.
module pwl_coeff_fetch #(
  parameter  int WIDTH = pwl_pkg::WIDTH,
  parameter  int NUM   = pwl_pkg::NUM,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_slope_i,
  input  logic [WIDTH-1:0] cfg_bias_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] s_i,
  input  logic [NUM-1:0]   interval_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] slope_o,
  output logic [WIDTH-1:0] bias_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
`ifdef PWL_STATS_EN
  , output logic [15:0]    err_cnt_o
`endif
);
  import pwl_pkg::*;

  localparam logic [IDX_W:0] ADDR_LIM = (IDX_W+1)'(NUM);

  logic             v1_q, v1_d, v2_q, v2_d;
  stage_t           s1_q, s1_d;
  coeff_t           tbl_q [NUM];
  logic [IDX_W-1:0] enc_idx;
  logic             enc_err;
  logic             load1, load2, out_fire;
  logic [WIDTH-1:0] s_q;
  coeff_t           coef_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;

  onehot_to_idx #(.NUM(NUM)) u_enc (
    .vec_i (interval_i),
    .idx_o (enc_idx),
    .err_o (enc_err)
  );

  assign out_fire   = v2_q & out_ready_i;
  assign in_ready_o = !v1_q | !v2_q | out_ready_i;
  assign load1      = in_valid_i & in_ready_o;
  assign load2      = v1_q & (!v2_q | out_ready_i);

  always_comb begin
    v1_d = v1_q;
    if (load1)      v1_d = 1'b1;
    else if (load2) v1_d = 1'b0;
    v2_d = v2_q;
    if (load2)         v2_d = 1'b1;
    else if (out_fire) v2_d = 1'b0;
    s1_d = s1_q;
    if (load1) s1_d = '{s: s_i, idx: enc_idx, err: enc_err};
  end

  // S1: sample, encoded index and error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
    end
  end

  // Table writes land at the edge, so an S2 read in the same cycle sees the old entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM; i++) tbl_q[i] <= '0;
    end else if (cfg_we_i && ({1'b0, cfg_addr_i} < ADDR_LIM)) begin
      tbl_q[cfg_addr_i] <= '{slope: cfg_slope_i, bias: cfg_bias_i};
    end
  end

  // S2: table lookup and output operand triple
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q    <= '0;
      coef_q <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else if (load2) begin
      s_q    <= s1_q.s;
      coef_q <= tbl_q[s1_q.idx];
      idx_q  <= s1_q.idx;
      err_q  <= s1_q.err;
    end
  end

  assign out_valid_o = v2_q;
  assign s_o         = s_q;
  assign slope_o     = coef_q.slope;
  assign bias_o      = coef_q.bias;
  assign idx_o       = idx_q;
  assign err_o       = err_q;

`ifdef PWL_STATS_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (out_fire && err_q && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pwl_coeff_fetch.sv
// Self-checking bench for pwl_coeff_fetch against a queue-based reference model.
module tb_pwl_coeff_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_we_i;
  logic [2:0]  cfg_addr_i;
  logic [15:0] cfg_slope_i, cfg_bias_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] s_i;
  logic [7:0]  interval_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] s_o, slope_o, bias_o;
  logic [2:0]  idx_o;
  logic        err_o;
`ifdef PWL_STATS_EN
  logic [15:0] err_cnt_o;
`endif

  pwl_coeff_fetch dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_slope_i (cfg_slope_i),
    .cfg_bias_i  (cfg_bias_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .s_i         (s_i),
    .interval_i  (interval_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .slope_o     (slope_o),
    .bias_o      (bias_o),
    .idx_o       (idx_o),
    .err_o       (err_o)
`ifdef PWL_STATS_EN
    , .err_cnt_o (err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] s;
    logic [15:0] sl;
    logic [15:0] bi;
    int          idx;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_sl[8];
  logic [15:0] m_bi[8];
  int          m_errcnt;
  int          n_chk;
  int          n_err;

  function automatic int ref_idx(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit ref_err(logic [7:0] v);
    return $countones(v) != 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      m_sl[i] = '0;
      m_bi[i] = '0;
    end
    m_errcnt = 0;
  endtask

  task automatic prog(logic [2:0] a, logic [15:0] sl, logic [15:0] bi);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_slope_i = sl; cfg_bias_i = bi;
    @(posedge clk_i);
    m_sl[a] = sl;
    m_bi[a] = bi;
    #1 cfg_we_i = 1'b0;
  endtask

  // One clock of streaming traffic checked against the in-flight queue.
  task automatic step(bit iv, logic [15:0] s, logic [7:0] v, bit ordy, output bit acc);
    bit   outf;
    exp_t e;
    @(negedge clk_i);
    in_valid_i = iv; s_i = s; interval_i = v; out_ready_i = ordy;
    #1;
    chk("in_ready", in_ready_o, (q.size() == 2 && !ordy) ? 0 : 1);
    if (out_valid_o) begin
      if (q.size() == 0) chk("spurious_valid", out_valid_o, 0);
      else begin
        chk("s_o", s_o, q[0].s);
        chk("slope_o", slope_o, q[0].sl);
        chk("bias_o", bias_o, q[0].bi);
        chk("idx_o", idx_o, q[0].idx);
        chk("err_o", err_o, q[0].err);
      end
    end
    acc  = iv && in_ready_o;
    outf = out_valid_o && ordy;
    @(posedge clk_i);
    if (outf && q.size() > 0) begin
      if (q[0].err && m_errcnt < 65535) m_errcnt++;
      void'(q.pop_front());
    end
    if (acc) begin
      e.s = s; e.idx = ref_idx(v); e.err = ref_err(v);
      e.sl = m_sl[e.idx]; e.bi = m_bi[e.idx];
      q.push_back(e);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 20 && q.size() > 0; k++) step(1'b0, 16'h0, 8'h0, 1'b1, acc);
    chk("drain_empty", q.size(), 0);
  endtask

  // Single sample into an empty pipe; checks the 2-cycle latency and the result.
  task automatic direct(string pfx, logic [15:0] s, logic [7:0] v,
                        logic [15:0] esl, logic [15:0] ebi, int eidx, bit eerr);
    @(negedge clk_i);
    in_valid_i = 1'b1; s_i = s; interval_i = v; out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1 chk({pfx, "_lat1_valid"}, out_valid_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk({pfx, "_valid"}, out_valid_o, 1);
    chk({pfx, "_s"}, s_o, s);
    chk({pfx, "_slope"}, slope_o, esl);
    chk({pfx, "_bias"}, bias_o, ebi);
    chk({pfx, "_idx"}, idx_o, eidx);
    chk({pfx, "_err"}, err_o, eerr);
    @(posedge clk_i);
    if (eerr && m_errcnt < 65535) m_errcnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    int          sent;
    int          r;
    logic [7:0]  v;
    logic [15:0] a_sl, a_bi, b_sl, b_bi;
    bit          rdy_pat[4];
    n_chk = 0; n_err = 0;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_slope_i = '0; cfg_bias_i = '0;
    in_valid_i = 1'b0; s_i = '0; interval_i = '0; out_ready_i = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_s", s_o, 0);
    chk("rst_slope", slope_o, 0);
    chk("rst_bias", bias_o, 0);
    chk("rst_idx", idx_o, 0);
    chk("rst_err", err_o, 0);
`ifdef PWL_STATS_EN
    chk("rst_errcnt", err_cnt_o, 0);
`endif

    prog(3'd3, 16'h3800, 16'h3C00);
    direct("basic", 16'h4000, 8'b0000_1000, 16'h3800, 16'h3C00, 3, 1'b0);
    direct("zero", 16'h1234, 8'b0000_0000, m_sl[0], m_bi[0], 0, 1'b1);
    direct("multi", 16'h5678, 8'b0010_0100, m_sl[2], m_bi[2], 2, 1'b1);

    for (int i = 0; i < 8; i++) prog(3'(i), 16'($urandom), 16'($urandom));
    sent = 0;
    for (int k = 0; k < 100 && sent < 8; k++) begin
      step(1'b1, 16'($urandom), 8'(1) << sent, rdy_pat[k % 4], acc);
      if (acc) sent++;
    end
    chk("stream_sent", sent, 8);
    drain();

    for (int k = 0; k < 2000; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       v = 8'(1) << $urandom_range(0, 7);
      else if (r == 7) v = 8'h00;
      else             v = 8'($urandom);
      step($urandom_range(0, 3) != 0, 16'($urandom), v, $urandom_range(0, 4) > 1, acc);
    end
    drain();
`ifdef PWL_STATS_EN
    chk("rand_errcnt", err_cnt_o, m_errcnt);
`endif

    a_sl = 16'h1111; a_bi = 16'h2222; b_sl = 16'hAAAA; b_bi = 16'hBBBB;
    prog(3'd5, a_sl, a_bi);
    @(negedge clk_i);
    in_valid_i = 1'b1; s_i = 16'h0505; interval_i = 8'b0010_0000; out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    cfg_we_i = 1'b1; cfg_addr_i = 3'd5; cfg_slope_i = b_sl; cfg_bias_i = b_bi;
    @(posedge clk_i);
    m_sl[5] = b_sl; m_bi[5] = b_bi;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    #1;
    chk("coll_valid", out_valid_o, 1);
    chk("coll_slope_old", slope_o, a_sl);
    chk("coll_bias_old", bias_o, a_bi);
    @(posedge clk_i);
    direct("coll_next", 16'h0606, 8'b0010_0000, b_sl, b_bi, 5, 1'b0);

    prog(3'd3, 16'h3800, 16'h3C00);
    @(negedge clk_i);
    in_valid_i = 1'b1; s_i = 16'hAAA1; interval_i = 8'b0000_1000; out_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    s_i = 16'hAAA2; interval_i = 8'b0001_0000;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("full_valid", out_valid_o, 1);
    chk("full_in_ready", in_ready_o, 0);
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_slope", slope_o, 0);
    chk("midrst_s", s_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clear();
    #1 chk("midrst_in_ready", in_ready_o, 1);
    direct("post_rst", 16'h7777, 8'b0000_1000, 16'h0000, 16'h0000, 3, 1'b0);

    direct("e1", 16'h0001, 8'h00, 16'h0, 16'h0, 0, 1'b1);
    direct("e2", 16'h0002, 8'hFF, 16'h0, 16'h0, 0, 1'b1);
    direct("e3", 16'h0003, 8'b1100_0000, 16'h0, 16'h0, 6, 1'b1);
`ifdef PWL_STATS_EN
    chk("errcnt_3", err_cnt_o, m_errcnt);
    @(negedge clk_i);
    force dut.err_cnt_q = 16'hFFFF;
    @(posedge clk_i);
    @(negedge clk_i);
    release dut.err_cnt_q;
    m_errcnt = 65535;
    direct("sat", 16'h0004, 8'h00, 16'h0, 16'h0, 0, 1'b1);
    @(negedge clk_i);
    chk("errcnt_sat", err_cnt_o, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
